// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO with thresholds, flush and read-valid strobe
//
// Ports:
//   clk            - clock, all logic on the rising edge
//   reset          - synchronous active-low reset
//   push_i         - write request, data_in captured when accepted
//   pop_i          - read request, data_out loaded when accepted
//   flush_i        - synchronous clear of pointers and occupancy
//   data_in        - write data (WIDTH bits)
//   data_out       - registered read data (WIDTH bits), holds between pops
//   data_valid_o   - one-cycle pulse after an accepted pop
//   count_o        - occupancy 0..DEPTH
//   full_o         - count_o == DEPTH
//   empty_o        - count_o == 0
//   almost_full_o  - count_o >= AF_THRESH
//   almost_empty_o - count_o <= AE_THRESH
//   overflow_o     - sticky dropped-push flag (only with FIFO_ERR_STICKY_EN)
//   underflow_o    - sticky pop-while-empty flag (only with FIFO_ERR_STICKY_EN)
//
// Optional feature macro: FIFO_ERR_STICKY_EN

module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
`ifdef FIFO_ERR_STICKY_EN
    ,
    output logic                       overflow_o,
    output logic                       underflow_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_acc;
    logic             push_acc;

    // Flags come straight off the registered count so they never lag it.
    assign full_o         = (count_o == DEPTH_C);
    assign empty_o        = (count_o == '0);
    assign almost_full_o  = (count_o >= AF_C);
    assign almost_empty_o = (count_o <= AE_C);

    // Reset and flush both suppress traffic; gating here keeps the storage
    // write enable consistent with the pointer updates.
    assign pop_acc  = reset && !flush_i && pop_i && !empty_o;
    assign push_acc = reset && !flush_i && push_i && (!full_o || pop_acc);

    // Storage has no reset: stale words are never visible because the
    // pointers and count are what define the valid window.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            data_out     <= '0;
            data_valid_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_o      <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= pop_acc;
            // On push+pop when full, wr_ptr == rd_ptr; the non-blocking read
            // picks up the oldest word before the slot is overwritten.
            if (pop_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PW'(1);
            end
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_o && !pop_i) begin
                overflow_o <= 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param

module tb_fifo_sync_param;

    logic       clk;
    logic       reset;
    logic       push_i;
    logic       pop_i;
    logic       flush_i;
    logic [7:0] data_in;

    logic [7:0] data_out4;
    logic       dv4;
    logic [2:0] count4;
    logic       full4, empty4, af4, ae4;

    logic [7:0] data_out8;
    logic       dv8;
    logic [3:0] count8;
    logic       full8, empty8, af8, ae8;

`ifdef FIFO_ERR_STICKY_EN
    logic ovf4, unf4, ovf8, unf8;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_sync_param #(.WIDTH(8), .DEPTH(4)) u_dut4 (
`ifdef FIFO_ERR_STICKY_EN
        .overflow_o     (ovf4),
        .underflow_o    (unf4),
`endif
        .clk            (clk),
        .reset          (reset),
        .push_i         (push_i),
        .pop_i          (pop_i),
        .flush_i        (flush_i),
        .data_in        (data_in),
        .data_out       (data_out4),
        .data_valid_o   (dv4),
        .count_o        (count4),
        .full_o         (full4),
        .empty_o        (empty4),
        .almost_full_o  (af4),
        .almost_empty_o (ae4)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_dut8 (
`ifdef FIFO_ERR_STICKY_EN
        .overflow_o     (ovf8),
        .underflow_o    (unf8),
`endif
        .clk            (clk),
        .reset          (reset),
        .push_i         (push_i),
        .pop_i          (pop_i),
        .flush_i        (flush_i),
        .data_in        (data_in),
        .data_out       (data_out8),
        .data_valid_o   (dv8),
        .count_o        (count8),
        .full_o         (full8),
        .empty_o        (empty8),
        .almost_full_o  (af8),
        .almost_empty_o (ae8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given controls; outputs are settled on return.
    task automatic cyc(input logic p, input logic q, input logic f, input logic [7:0] d);
        push_i  = p;
        pop_i   = q;
        flush_i = f;
        data_in = d;
        @(posedge clk);
        #1;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
        data_in = 8'h00;

        // 1. reset and ordering
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        check_eq("rst_count", count4, 0);
        check_eq("rst_empty", empty4, 1);
        check_eq("rst_full", full4, 0);
        check_eq("rst_ae", ae4, 1);
        check_eq("rst_af", af4, 0);
        check_eq("rst_dout", data_out4, 0);
        check_eq("rst_dv", dv4, 0);
        reset = 1'b1;
        cyc(1, 0, 0, 8'h11);
        check_eq("t1_poppable_empty", empty4, 0);
        cyc(1, 0, 0, 8'h22);
        cyc(1, 0, 0, 8'h33);
        check_eq("t1_af_at3", af4, 1);
        check_eq("t1_full_at3", full4, 0);
        cyc(1, 0, 0, 8'h44);
        check_eq("t1_full", full4, 1);
        check_eq("t1_count4", count4, 4);
        cyc(0, 1, 0, 8'h00);
        check_eq("t1_pop0", data_out4, 8'h11);
        check_eq("t1_dv0", dv4, 1);
        cyc(0, 1, 0, 8'h00);
        check_eq("t1_pop1", data_out4, 8'h22);
        cyc(0, 1, 0, 8'h00);
        check_eq("t1_pop2", data_out4, 8'h33);
        cyc(0, 1, 0, 8'h00);
        check_eq("t1_pop3", data_out4, 8'h44);
        check_eq("t1_dv3", dv4, 1);
        cyc(0, 0, 0, 8'h00);
        check_eq("t1_dv_drop", dv4, 0);
        check_eq("t1_empty", empty4, 1);
        check_eq("t1_dout_hold", data_out4, 8'h44);

        // 2. overflow / underflow
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'hA0 + 8'(i));
        cyc(1, 0, 0, 8'hFF);
        check_eq("t2_count_ovf", count4, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            check_eq("t2_drain", data_out4, 8'hA0 + 8'(i));
        end
        cyc(0, 1, 0, 8'h00);
        check_eq("t2_unf_dout", data_out4, 8'hA3);
        check_eq("t2_unf_dv", dv4, 0);
        check_eq("t2_unf_count", count4, 0);
`ifdef FIFO_ERR_STICKY_EN
        check_eq("t2_ovf_flag", ovf4, 1);
        check_eq("t2_unf_flag", unf4, 1);
        cyc(0, 0, 1, 8'h00);
        check_eq("t2_ovf_clr", ovf4, 0);
        check_eq("t2_unf_clr", unf4, 0);
`endif

        // 3. simultaneous push and pop
        cyc(1, 1, 0, 8'h5A);
        check_eq("t3_empty_pp_count", count4, 1);
        check_eq("t3_empty_pp_dv", dv4, 0);
        cyc(0, 1, 0, 8'h00);
        check_eq("t3_5a", data_out4, 8'h5A);
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 8'(i));
        cyc(1, 1, 0, 8'h05);
        check_eq("t3_full_pp_dout", data_out4, 8'h01);
        check_eq("t3_full_pp_dv", dv4, 1);
        check_eq("t3_full_pp_count", count4, 4);
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 1, 0, 8'h00);
            check_eq("t3_drain", data_out4, 8'(i));
        end
        check_eq("t3_empty", empty4, 1);

        // 4. wrap-around, interleaved push/pop
        cyc(1, 0, 0, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 1, 0, 8'(i));
            check_eq("t4_seq", data_out4, 8'(i - 1));
            check_eq("t4_count", count4, 1);
        end
        cyc(0, 1, 0, 8'h00);
        check_eq("t4_last", data_out4, 8'h09);
        check_eq("t4_count_end", count4, 0);

        // 5. thresholds on the DEPTH=8 instance
        cyc(0, 0, 1, 8'h00);
        check_eq("t5_ae_at0", ae8, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 8'h80 + 8'(i));
            if (i == 1) check_eq("t5_ae_at2", ae8, 1);
            if (i == 2) check_eq("t5_ae_at3", ae8, 0);
            if (i == 4) check_eq("t5_af_at5", af8, 0);
        end
        check_eq("t5_af_at6", af8, 1);
        check_eq("t5_count6", count8, 6);
        check_eq("t5_full8", full8, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            check_eq("t5_dout8", data_out8, 8'h80 + 8'(i));
            if (i == 2) check_eq("t5_ae_c3", ae8, 0);
        end
        check_eq("t5_count2", count8, 2);
        check_eq("t5_ae_c2", ae8, 1);
        check_eq("t5_af_c2", af8, 0);

        // 6. flush and mid-operation reset
        cyc(0, 0, 1, 8'h00);
        check_eq("t6_dout_before", data_out4, 8'h83);
        cyc(1, 0, 0, 8'hC1);
        cyc(1, 0, 0, 8'hC2);
        cyc(1, 0, 0, 8'hC3);
        check_eq("t6_count3", count4, 3);
        cyc(1, 0, 1, 8'hD0);
        check_eq("t6_flush_count", count4, 0);
        check_eq("t6_flush_empty", empty4, 1);
        check_eq("t6_flush_dout", data_out4, 8'h83);
        check_eq("t6_flush_dv", dv4, 0);
        cyc(1, 0, 0, 8'hE1);
        cyc(1, 0, 0, 8'hE2);
        cyc(0, 1, 0, 8'h00);
        check_eq("t6_refill_pop", data_out4, 8'hE1);
        cyc(1, 0, 0, 8'hE3);
        check_eq("t6_count2", count4, 2);
        reset = 1'b0;
        cyc(0, 1, 0, 8'h00);
        check_eq("t6_rst_count", count4, 0);
        check_eq("t6_rst_dout", data_out4, 0);
        check_eq("t6_rst_dv", dv4, 0);
        check_eq("t6_rst_empty", empty4, 1);
        reset = 1'b1;
        cyc(0, 0, 0, 8'h00);
        check_eq("t6_post_rst_dv", dv4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
